// File: rtl/ksa_adder_pipe_if.sv
// ksa_adder_pipe_if: operand/result handshake bundle for ksa_adder_pipe
interface ksa_adder_pipe_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
);
    logic              in_valid, in_ready, in_cin, in_sub;
    logic [DATA_W-1:0] in_a, in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid, out_ready, out_cout, out_ovf;
    logic [DATA_W-1:0] out_sum;
    logic [TAG_W-1:0]  out_tag;
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
    );
endinterface

// File: rtl/ksa_adder_pipe.sv
// ksa_adder_pipe: pipelined Kogge-Stone adder/subtractor, one register per prefix level
module ksa_adder_pipe #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input logic clk,
    input logic rst,
    ksa_adder_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(DATA_W);
    localparam int PL = LEVELS > 0 ? LEVELS - 1 : 0;
    logic adv, c0;
    logic [DATA_W-1:0] b_c, sum_c;
    logic [DATA_W:0] cv;
    logic [LEVELS:0][DATA_W-1:0] g_r, s_r, gn;
    logic [PL:0][DATA_W-1:0] p_r, pn;
    logic [LEVELS:0][TAG_W-1:0] t_r;
    logic [LEVELS:0] v_r, c_r, am_r, bm_r;
    assign adv = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;
    assign b_c = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign c0 = bus.in_sub | bus.in_cin;
    assign pn[0] = bus.in_a ^ b_c;
    // carry-in enters as a generate at bit -1, so final G[i] is the true carry out of bit i
    assign gn[0] = (bus.in_a & b_c) | DATA_W'(pn[0][0] & c0);
    for (genvar k = 1; k <= LEVELS; k++) begin : lvl
        localparam int S = 1 << (k - 1);
        for (genvar i = 0; i < DATA_W; i++) begin : bt
            if (i >= S) begin : cmb
                assign gn[k][i] = g_r[k-1][i] | (p_r[k-1][i] & g_r[k-1][i-S]);
                if (k < LEVELS) begin : pp
                    assign pn[k][i] = p_r[k-1][i] & p_r[k-1][i-S];
                end
            end else begin : pass
                assign gn[k][i] = g_r[k-1][i];
                if (k < LEVELS) begin : pp
                    assign pn[k][i] = p_r[k-1][i];
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r <= '0;
        end else if (adv) begin
            v_r[0]  <= bus.in_valid;
            g_r[0]  <= gn[0];
            p_r[0]  <= pn[0];
            s_r[0]  <= pn[0];
            c_r[0]  <= c0;
            t_r[0]  <= bus.in_tag;
            am_r[0] <= bus.in_a[DATA_W-1];
            bm_r[0] <= b_c[DATA_W-1];
            for (int k = 1; k <= LEVELS; k++) begin
                v_r[k]  <= v_r[k-1];
                g_r[k]  <= gn[k];
                s_r[k]  <= s_r[k-1];
                c_r[k]  <= c_r[k-1];
                t_r[k]  <= t_r[k-1];
                am_r[k] <= am_r[k-1];
                bm_r[k] <= bm_r[k-1];
            end
            for (int k = 1; k < LEVELS; k++) p_r[k] <= pn[k];
        end
    end
    assign cv = {g_r[LEVELS], c_r[LEVELS]};
    assign sum_c = s_r[LEVELS] ^ cv[DATA_W-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_tag   <= '0;
        end else if (adv) begin
            bus.out_valid <= v_r[LEVELS];
            if (v_r[LEVELS]) begin
                bus.out_sum  <= sum_c;
                bus.out_cout <= cv[DATA_W];
                bus.out_ovf  <= (am_r[LEVELS] == bm_r[LEVELS]) && (sum_c[DATA_W-1] != am_r[LEVELS]);
                bus.out_tag  <= t_r[LEVELS];
            end
        end
    end
endmodule

// File: tb/tb_ksa_adder_pipe.sv
// tb_ksa_adder_pipe: scoreboard bench for ksa_adder_pipe at widths 16, 3 and 1
module tb_ksa_adder_pipe;
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } res_t;
    logic clk = 0, rst = 1;
    int checks = 0, errors = 0;
    res_t q[$];
    res_t e;
    logic [15:0] ss;
    logic [3:0] st;
    ksa_adder_pipe_if #(.DATA_W(16), .TAG_W(4)) bus();
    ksa_adder_pipe_if #(.DATA_W(3), .TAG_W(4)) b3();
    ksa_adder_pipe_if #(.DATA_W(1), .TAG_W(4)) b1();
    ksa_adder_pipe #(.DATA_W(16), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    ksa_adder_pipe #(.DATA_W(3), .TAG_W(4)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
    ksa_adder_pipe #(.DATA_W(1), .TAG_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub, input logic [3:0] tag);
        res_t r;
        int s;
        if (sub) begin
            r.sum = a - b;
            r.cout = a >= b;
            s = int'($signed(a)) - int'($signed(b));
        end else begin
            {r.cout, r.sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            s = int'($signed(a)) + int'($signed(b)) + int'({31'd0, cin});
        end
        r.ovf = s > 32767 || s < -32768;
        r.tag = tag;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_sum", {16'd0, bus.out_sum}, {16'd0, e.sum});
                    chk("sb_cout", {31'd0, bus.out_cout}, {31'd0, e.cout});
                    chk("sb_ovf", {31'd0, bus.out_ovf}, {31'd0, e.ovf});
                    chk("sb_tag", {28'd0, bus.out_tag}, {28'd0, e.tag});
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub, bus.in_tag));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [3:0] tag);
        int n = 0;
        bus.in_valid = 1; bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub; bus.in_tag = tag;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 0;
    endtask

    task automatic dir16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                         input logic [3:0] tag, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        bus.in_valid = 1; bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub; bus.in_tag = tag;
        @(posedge clk);
        #1 bus.in_valid = 0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("lat16", lat, 6);
        chk("dir_sum", {16'd0, bus.out_sum}, {16'd0, es});
        chk("dir_cout", {31'd0, bus.out_cout}, {31'd0, ec});
        chk("dir_ovf", {31'd0, bus.out_ovf}, {31'd0, eo});
        chk("dir_tag", {28'd0, bus.out_tag}, {28'd0, tag});
        @(posedge clk);
        #1;
    endtask

    task automatic small_op(input logic w3, input logic [2:0] a, input logic [2:0] b, input logic cin,
                            input logic [2:0] es, input logic ec, input logic eo, input int el);
        int lat;
        if (w3) begin
            b3.in_valid = 1; b3.in_a = a; b3.in_b = b; b3.in_cin = cin; b3.in_sub = 0; b3.in_tag = 4'h9;
        end else begin
            b1.in_valid = 1; b1.in_a = a[0]; b1.in_b = b[0]; b1.in_cin = cin; b1.in_sub = 0; b1.in_tag = 4'h6;
        end
        @(posedge clk);
        #1 b3.in_valid = 0; b1.in_valid = 0;
        lat = 1;
        while (!(w3 ? b3.out_valid : b1.out_valid) && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk(w3 ? "lat3" : "lat1", lat, el);
        chk(w3 ? "sum3" : "sum1", {29'd0, w3 ? b3.out_sum : {2'b0, b1.out_sum}}, {29'd0, es});
        chk(w3 ? "cout3" : "cout1", {31'd0, w3 ? b3.out_cout : b1.out_cout}, {31'd0, ec});
        chk(w3 ? "ovf3" : "ovf1", {31'd0, w3 ? b3.out_ovf : b1.out_ovf}, {31'd0, eo});
        chk(w3 ? "tag3" : "tag1", {28'd0, w3 ? b3.out_tag : b1.out_tag}, w3 ? 32'h9 : 32'h6);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_cin = 0; bus.in_sub = 0; bus.in_tag = 0; bus.out_ready = 1;
        b3.in_valid = 0; b3.in_a = 0; b3.in_b = 0; b3.in_cin = 0; b3.in_sub = 0; b3.in_tag = 0; b3.out_ready = 1;
        b1.in_valid = 0; b1.in_a = 0; b1.in_b = 0; b1.in_cin = 0; b1.in_sub = 0; b1.in_tag = 0; b1.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_sum", {16'd0, bus.out_sum}, 32'd0);
        chk("rst_out_cout", {31'd0, bus.out_cout}, 32'd0);
        chk("rst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
        chk("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_valid3", {31'd0, b3.out_valid}, 32'd0);
        chk("rst_valid1", {31'd0, b1.out_valid}, 32'd0);
        rst = 0;
        dir16(16'h1234, 16'h0FED, 1, 0, 4'd3, 16'h2222, 0, 0);
        dir16(16'hFFFF, 16'h0000, 1, 0, 4'd5, 16'h0000, 1, 0);
        dir16(16'h0005, 16'h0007, 1, 1, 4'd7, 16'hFFFE, 0, 0);
        dir16(16'h8000, 16'h0001, 1, 1, 4'd8, 16'h7FFF, 1, 1);
        fork
            for (int i = 0; i < 20; i++)
                send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4'(i % 16));
            begin
                repeat (10) @(posedge clk);
                #1 bus.out_ready = 0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    if (j == 0) begin
                        ss = bus.out_sum;
                        st = bus.out_tag;
                        chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                    end else begin
                        chk("stall_sum", {16'd0, bus.out_sum}, {16'd0, ss});
                        chk("stall_tag", {28'd0, bus.out_tag}, {28'd0, st});
                        chk("stall_valid_hold", {31'd0, bus.out_valid}, 32'd1);
                    end
                    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                end
                @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        repeat (12) @(posedge clk);
        #1 chk("drain_empty", q.size(), 0);
        for (int i = 0; i < 4; i++) send(16'(i * 4097 + 3), 16'h1111, 0, 0, 4'(i));
        rst = 1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_sum", {16'd0, bus.out_sum}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 0;
        repeat (12) @(posedge clk);
        #1;
        chk("no_stale", {31'd0, bus.out_valid}, 32'd0);
        chk("no_stale_q", q.size(), 0);
        small_op(1, 3'd1, 3'd1, 1, 3'd3, 0, 0, 4);
        small_op(1, 3'd7, 3'd1, 0, 3'd0, 1, 0, 4);
        small_op(1, 3'd3, 3'd1, 0, 3'd4, 0, 1, 4);
        small_op(0, 3'd1, 3'd1, 1, 3'd1, 1, 0, 2);
        small_op(0, 3'd1, 3'd0, 0, 3'd1, 0, 0, 2);
        b1.in_valid = 1; b1.in_a = 1; b1.in_b = 1; b1.in_cin = 1; b1.in_sub = 0; b1.in_tag = 4'h2;
        @(posedge clk);
        #1 b1.in_valid = 0; rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("w1_rst_valid", {31'd0, b1.out_valid}, 32'd0);
        chk("w1_rst_sum", {31'd0, b1.out_sum}, 32'd0);
        chk("w3_rst_sum", {29'd0, b3.out_sum}, 32'd0);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1 chk("w1_no_stale", {31'd0, b1.out_valid}, 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ksa_adder_pipe.md
Name: ksa_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor with a valid/ready handshake. It is the successor to the fixed-width combinational prefix adder.
- Width is generic. One register stage sits after each prefix level, and a sideband tag travels with each operation.
- Used in the FIFO pointer/occupancy datapaths and in any wide add that must close timing at the core clock.

Parameters:
- DATA_W, 16, operand/sum width in bits (≥1).
- TAG_W, 4, width of sideband tag carried alongside each operation (≥1).
- LEVELS, $clog2(DATA_W), derived (localparam, not overridable): number of prefix levels. Equals 0 when DATA_W=1.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_cin  in  1  carry-in (add mode only).
- in_sub  in  1  1 = subtract (A − B), 0 = add (A + B + cin).
- in_tag  in  TAG_W  opaque tag, returned unchanged with result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  DATA_W  result.
- out_cout  out  1  carry-out of MSB (borrow-not for subtract).
- out_ovf  out  1  signed two's-complement overflow.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on clk edge with rst=1, all stage valid bits clear. out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_tag=0. in_ready=1 from the first cycle after reset. rst has priority over any transfer in the same cycle; in-flight operations are discarded.
- Operand conditioning:
  - sub=1: b' = ~in_b, c0 = 1, and in_cin is ignored.
  - sub=0: b' = in_b, c0 = in_cin.
- Stage 0 (input register, on accept):
  - p = a ^ b', g = a & b', plus a copy of p for the sum.
  - Also registers c0, tag, and the operand sign bits a[MSB] and b'[MSB].
- Prefix stages 1..LEVELS (one register each):
  - Level k combines bit i with bit i − 2^(k−1) for i ≥ 2^(k−1): G = g_i | (p_i & g_j), P = p_i & p_j.
  - Bits below the span pass through unchanged.
  - c0 is folded in as generate at bit −1, i.e. g0' = g0 | (p0 & c0) at stage 0.
- Output stage:
  - sum[0] = p0 ^ c0 and sum[i] = p_i ^ G[i−1].
  - cout = G[DATA_W−1].
  - ovf = (a_msb == b'_msb) && (sum[MSB] != a_msb).
- Latency: exactly LEVELS+2 edges from accept (in_valid & in_ready) to out_valid=1 with no stall. This is 6 for DATA_W=16 and 2 for DATA_W=1.
- Pipeline stalls as a whole:
  - adv = ~out_valid | out_ready; in_ready = adv.
  - When adv=0, every stage, including the output register, holds its contents.
  - Bubbles are not collapsed.
- Throughput: one operation per cycle while out_ready=1.
- Ordering: results emerge in accept order. out_tag always matches the tag of the operation producing out_sum.
- Output stability: out_valid=1 with out_ready=0 keeps all out_* stable until the handshake completes.
- in_valid=0 on an advancing cycle inserts a bubble (stage valid=0). Data fields of invalid stages are don't-care but must not reach out_* while out_valid=0; out_* holds its last value.
- Width rules: all arithmetic is modulo 2^DATA_W, carry out goes to out_cout, and there is no saturation.

Test Plan:
- Single add, DATA_W=16: A=0x1234, B=0x0FED, cin=1, tag=3 -> after 6 cycles out_sum=0x2222, cout=0, ovf=0, tag=3.
- Full carry ripple: A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
- Subtract, with in_cin=1 (ignored):
  - A=0x0005, B=0x0007 -> sum=0xFFFE, cout=0.
  - A=0x8000, B=0x0001 -> sum=0x7FFF, ovf=1.
- Back-to-back stream: 20 random ops, tags 0..15 wrapping, out_ready=1 -> one result per cycle in order, all matching the reference model.
- Backpressure: stream with out_ready held 0 for 5 cycles mid-burst.
  - in_ready=0 throughout; out_* stable; no loss or duplication.
  - Tag sequence intact after release.
- Reset mid-operation: assert rst with 4 ops in flight -> next cycle out_valid=0, out_sum=0, in_ready=1, and no stale results later. Repeat with DATA_W=1 (latency 2) and DATA_W=3: 1+1+cin=1 -> sum=1, cout=1.
